// File: rtl/ps2_ace_pkg.sv
// rtl/ps2_ace_pkg.sv - shared types and constants for the PS/2 to Jupiter Ace keyboard bridge
package ps2_ace_pkg;

  localparam int PS2_TIMEOUT = 4095;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic ext;
    logic rel;
  } dec_flags_t;

  typedef struct packed {
    logic lshift;
    logic rshift;
    logic lctrl;
    logic rctrl;
    logic lalt;
    logic ralt;
  } held_t;

  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_REL    = 8'hF0;
  localparam logic [7:0] CODE_PAUSE  = 8'hE1;
  localparam logic [7:0] CODE_BAT_OK = 8'hAA;
  localparam logic [7:0] CODE_ACK    = 8'hFA;
  localparam logic [7:0] CODE_RESEND = 8'hFE;
  localparam logic [7:0] CODE_ECHO   = 8'hEE;

  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CTRL   = 8'h14;
  localparam logic [7:0] KEY_ALT    = 8'h11;
  localparam logic [7:0] KEY_DEL    = 8'h71;

  function automatic logic is_ignored(input logic [7:0] code);
    return code inside {CODE_PAUSE, CODE_BAT_OK, CODE_ACK, CODE_RESEND, CODE_ECHO};
  endfunction

endpackage

// File: rtl/ps2_ace_keymap.sv
// rtl/ps2_ace_keymap.sv - combinational scancode to Ace matrix (row, column) lookup
module ps2_ace_keymap
  import ps2_ace_pkg::*;
(
  input  logic       ext_i,
  input  logic [7:0] code_i,
  output logic       valid_o,
  output logic [2:0] row_o,
  output logic [2:0] col_o
);

  logic [5:0] rc;

  // rc is {row, column} written as two octal digits
  always_comb begin
    valid_o = 1'b1;
    rc      = 6'o00;
    case (code_i)
      8'h12, 8'h59: rc = 6'o00;
      8'h14:        rc = 6'o01;
      8'h1A:        rc = 6'o02;
      8'h22:        rc = 6'o03;
      8'h21:        rc = 6'o04;
      8'h1C:        rc = 6'o10;
      8'h1B:        rc = 6'o11;
      8'h23:        rc = 6'o12;
      8'h2B:        rc = 6'o13;
      8'h34:        rc = 6'o14;
      8'h15:        rc = 6'o20;
      8'h1D:        rc = 6'o21;
      8'h24:        rc = 6'o22;
      8'h2D:        rc = 6'o23;
      8'h2C:        rc = 6'o24;
      8'h16:        rc = 6'o30;
      8'h1E:        rc = 6'o31;
      8'h26:        rc = 6'o32;
      8'h25:        rc = 6'o33;
      8'h2E:        rc = 6'o34;
      8'h45:        rc = 6'o40;
      8'h46:        rc = 6'o41;
      8'h3E:        rc = 6'o42;
      8'h3D:        rc = 6'o43;
      8'h36:        rc = 6'o44;
      8'h4D:        rc = 6'o50;
      8'h44:        rc = 6'o51;
      8'h43:        rc = 6'o52;
      8'h3C:        rc = 6'o53;
      8'h35:        rc = 6'o54;
      8'h5A:        rc = 6'o60;
      8'h4B:        rc = 6'o61;
      8'h42:        rc = 6'o62;
      8'h3B:        rc = 6'o63;
      8'h33:        rc = 6'o64;
      8'h29:        rc = 6'o70;
      8'h3A:        rc = 6'o71;
      8'h31:        rc = 6'o72;
      8'h32:        rc = 6'o73;
      8'h2A:        rc = 6'o74;
      default:      valid_o = 1'b0;
    endcase
    // right Ctrl arrives as E0 14 and must land on SYMSHIFT
    if (ext_i && code_i == KEY_CTRL) begin
      valid_o = 1'b1;
      rc      = 6'o01;
    end
  end

  assign row_o = rc[5:3];
  assign col_o = rc[2:0];

endmodule

// File: rtl/ps2_ace_keyboard.sv
// rtl/ps2_ace_keyboard.sv - PS/2 receiver, scancode decoder and 8x5 Ace key matrix
module ps2_ace_keyboard
  import ps2_ace_pkg::*;
#(
  parameter int TIMEOUT = PS2_TIMEOUT,
  parameter int CLK_HZ  = 6500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic [7:0] filas,
  output logic [4:0] columnas,
  output logic       kbd_reset
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // CLK_HZ documents the clock rate only; nothing is derived from it
  if (CLK_HZ <= 0) begin : g_clk_hz_unset
  end

  logic [2:0]      ps2clk_sync_q;
  logic [1:0]      ps2data_sync_q;
  logic            ps2_fall;
  logic            ps2_bit;

  rx_state_e       rx_state_q, rx_state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            code_valid_q, code_valid_d;

  dec_flags_t      flags_q, flags_d;
  held_t           held_q, held_d;
  logic [7:0][4:0] matrix_q, matrix_d;
  logic            kbd_reset_q, kbd_reset_d;

  logic            km_valid;
  logic [2:0]      km_row;
  logic [2:0]      km_col;
  logic            make;

  assign ps2_fall = ps2clk_sync_q[2] & ~ps2clk_sync_q[1];
  assign ps2_bit  = ps2data_sync_q[1];

  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    timer_d      = '0;
    code_valid_d = 1'b0;
    if (ps2_fall) begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!ps2_bit) begin
            rx_state_d = RX_DATA;
            bit_cnt_d  = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {ps2_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_PARITY;
        end
        RX_PARITY: rx_state_d = (^{shift_q, ps2_bit}) ? RX_STOP : RX_IDLE;
        RX_STOP: begin
          code_valid_d = ps2_bit;
          rx_state_d   = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end else if (rx_state_q != RX_IDLE) begin
      if (timer_q == TW'(TIMEOUT - 1)) rx_state_d = RX_IDLE;
      else                             timer_d    = timer_q + 1'b1;
    end
  end

  ps2_ace_keymap u_keymap (
    .ext_i   (flags_q.ext),
    .code_i  (shift_q),
    .valid_o (km_valid),
    .row_o   (km_row),
    .col_o   (km_col)
  );

  // shift_q stays stable for many cycles after a frame, so it doubles as the decoded byte
  always_comb begin
    flags_d     = flags_q;
    held_d      = held_q;
    matrix_d    = matrix_q;
    kbd_reset_d = 1'b0;
    make        = ~flags_q.rel;
    if (code_valid_q) begin
      if (shift_q == CODE_EXT) begin
        flags_d.ext = 1'b1;
      end else if (shift_q == CODE_REL) begin
        flags_d.rel = 1'b1;
      end else if (!is_ignored(shift_q)) begin
        flags_d = '0;
        if (km_valid) matrix_d[km_row][km_col] = make;
        if (shift_q == KEY_LSHIFT) held_d.lshift = make;
        if (shift_q == KEY_RSHIFT) held_d.rshift = make;
        if (shift_q == KEY_CTRL) begin
          if (flags_q.ext) held_d.rctrl = make;
          else             held_d.lctrl = make;
        end
        if (shift_q == KEY_ALT) begin
          if (flags_q.ext) held_d.ralt = make;
          else             held_d.lalt = make;
        end
        kbd_reset_d = make && flags_q.ext && (shift_q == KEY_DEL) &&
                      (held_q.lctrl || held_q.rctrl) && (held_q.lalt || held_q.ralt);
      end
    end
    // SHIFT releases only once neither physical shift key is down
    matrix_d[0][0] = held_d.lshift | held_d.rshift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps2clk_sync_q  <= 3'b111;
      ps2data_sync_q <= 2'b11;
      rx_state_q     <= RX_IDLE;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      timer_q        <= '0;
      code_valid_q   <= 1'b0;
      flags_q        <= '0;
      held_q         <= '0;
      matrix_q       <= '0;
      kbd_reset_q    <= 1'b0;
    end else begin
      ps2clk_sync_q  <= {ps2clk_sync_q[1:0], ps2clk};
      ps2data_sync_q <= {ps2data_sync_q[0], ps2data};
      rx_state_q     <= rx_state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      timer_q        <= timer_d;
      code_valid_q   <= code_valid_d;
      flags_q        <= flags_d;
      held_q         <= held_d;
      matrix_q       <= matrix_d;
      kbd_reset_q    <= kbd_reset_d;
    end
  end

  always_comb begin
    columnas = 5'b11111;
    for (int r = 0; r < 8; r++) begin
      if (!filas[r]) columnas = columnas & ~matrix_q[r];
    end
  end

  assign kbd_reset = kbd_reset_q;

endmodule

// File: tb/tb_ps2_ace_keyboard.sv
// tb/tb_ps2_ace_keyboard.sv - scoreboard bench for ps2_ace_keyboard with a behavioural key model
module tb_ps2_ace_keyboard;

  localparam int TMO  = 64;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic [7:0] filas = 8'hFF;
  logic [4:0] columnas;
  logic       kbd_reset;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] f;
    logic [4:0] e;
  } probe_t;

  probe_t probe_q[$];
  string  name_q[$];
  int     kbd_q[$];
  logic   kbd_prev = 1'b0;

  bit   mat[8][5];
  bit   m_ext, m_rel, lsh, rsh, lctrl, rctrl, lalt, ralt;
  int   km[int];
  logic [7:0] kcodes[$];

  ps2_ace_keyboard #(.TIMEOUT(TMO), .CLK_HZ(6500000)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2clk   (ps2clk),
    .ps2data  (ps2data),
    .filas    (filas),
    .columnas (columnas),
    .kbd_reset(kbd_reset)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    probe_t p;
    string  nm;
    if (probe_q.size() > 0) begin
      p  = probe_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if (columnas !== p.e) begin
        n_err++;
        $display("FAIL %s: filas=%h columnas=%b expected=%b", nm, p.f, columnas, p.e);
      end
    end
    if (kbd_reset !== 1'b0) begin
      n_cmp++;
      if (kbd_prev === 1'b1) begin
        n_err++;
        $display("FAIL kbd_width: kbd_reset=%b for a second clk, expected 0", kbd_reset);
      end else if (kbd_q.size() == 0) begin
        n_err++;
        $display("FAIL kbd_unexpected: kbd_reset=%b expected 0", kbd_reset);
      end else begin
        void'(kbd_q.pop_front());
      end
    end
    kbd_prev = kbd_reset;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic init_model();
    logic [7:0] tbl[8][5];
    tbl = '{'{8'h12, 8'h14, 8'h1A, 8'h22, 8'h21}, '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
            '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C}, '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
            '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36}, '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
            '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33}, '{8'h29, 8'h3A, 8'h31, 8'h32, 8'h2A}};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++) begin
        km[int'(tbl[r][c])] = r * 5 + c;
        kcodes.push_back(tbl[r][c]);
      end
    km[8'h59] = 0;
  endtask

  task automatic clear_model();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++) mat[r][c] = 1'b0;
    {m_ext, m_rel, lsh, rsh, lctrl, rctrl, lalt, ralt} = '0;
  endtask

  task automatic model_apply(input logic [7:0] b);
    bit mk;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else if (!(b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE})) begin
      mk = !m_rel;
      if (mk && m_ext && b == 8'h71 && (lctrl || rctrl) && (lalt || ralt)) kbd_q.push_back(1);
      if (b == 8'h12) lsh = mk;
      else if (b == 8'h59) rsh = mk;
      else if (km.exists(int'(b))) mat[km[int'(b)] / 5][km[int'(b)] % 5] = mk;
      mat[0][0] = lsh || rsh;
      if (b == 8'h14) begin if (m_ext) rctrl = mk; else lctrl = mk; end
      if (b == 8'h11) begin if (m_ext) ralt = mk; else lalt = mk; end
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  function automatic logic [4:0] model_cols(input logic [7:0] f);
    logic [4:0] res = 5'b11111;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!f[r] && mat[r][c]) res[c] = 1'b0;
    return res;
  endfunction

  function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      ps2data = bits[i];
      tick(HALF);
      ps2clk = 1'b0;
      tick(HALF);
      ps2clk = 1'b1;
      if (i == 4 && gap > 0) tick(gap);
    end
    ps2data = 1'b1;
    tick(4 * HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_apply(b);
    send_bits(frame(b, 1'b0, 1'b0), 11, 0);
  endtask

  task automatic probe(input logic [7:0] f, input logic [4:0] e, input string nm);
    filas = f;
    probe_q.push_back('{f, e});
    name_q.push_back(nm);
    tick(1);
    tick(1);
  endtask

  task automatic probe_model(input logic [7:0] f);
    probe(f, model_cols(f), "columnas_rand");
  endtask

  function automatic logic [7:0] rand_code();
    int k;
    logic [7:0] sp[4];
    logic [7:0] ig[5];
    sp = '{8'h12, 8'h59, 8'h14, 8'h11};
    ig = '{8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE};
    k = $urandom_range(0, 99);
    if (k < 25) return ($urandom_range(0, 1) != 0) ? 8'hE0 : 8'hF0;
    if (k < 70) return kcodes[$urandom_range(0, kcodes.size() - 1)];
    if (k < 80) return sp[$urandom_range(0, 3)];
    if (k < 85) return 8'h71;
    if (k < 90) return ig[$urandom_range(0, 4)];
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic logic [7:0] rand_filas();
    int k = $urandom_range(0, 9);
    if (k < 5) return ~(8'h01 << $urandom_range(0, 7));
    if (k < 8) return 8'($urandom_range(0, 255));
    return (k == 8) ? 8'h00 : 8'hFF;
  endfunction

  initial begin
    int act;
    init_model();
    clear_model();
    tick(3);
    probe(8'h00, 5'b11111, "reset_columnas");
    n_cmp++;
    if (kbd_reset !== 1'b0) begin
      n_err++;
      $display("FAIL reset_kbd: kbd_reset=%b expected 0", kbd_reset);
    end
    reset = 1'b0;
    tick(4);

    send_byte(8'h1C);              probe(8'hFD, 5'b11110, "s1_make_a");
    send_byte(8'hF0); send_byte(8'h1C); probe(8'hFD, 5'b11111, "s1_break_a");

    send_byte(8'h12);              probe(8'hFE, 5'b11110, "s2_lshift");
    send_byte(8'h59);              probe(8'hFE, 5'b11110, "s2_both");
    send_byte(8'hF0); send_byte(8'h12); probe(8'hFE, 5'b11110, "s2_rshift_held");
    send_byte(8'hF0); send_byte(8'h59); probe(8'hFE, 5'b11111, "s2_none");

    send_bits(frame(8'h1C, 1'b1, 1'b0), 11, 0); probe(8'hFD, 5'b11111, "s3_bad_parity");
    send_byte(8'h1C);              probe(8'hFD, 5'b11110, "s3_good_after");
    send_byte(8'hF0); send_byte(8'h1C);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11, 0); probe(8'hFD, 5'b11111, "s3_bad_stop");

    send_bits(frame(8'h16, 1'b0, 1'b0), 5, 0);
    tick(TMO + 16);
    send_byte(8'h29);              probe(8'h7F, 5'b11110, "s4_after_timeout");
    send_byte(8'hF0);
    model_apply(8'h29);
    send_bits(frame(8'h29, 1'b0, 1'b0), 11, TMO - 24);
    probe(8'h7F, 5'b11111, "s4_slow_frame");

    send_byte(8'h15); send_byte(8'h1C);
    probe(8'hF9, 5'b11110, "s5_two_rows");
    probe(8'hFF, 5'b11111, "s5_no_row");
    send_byte(8'hF0); send_byte(8'h15); send_byte(8'hF0); send_byte(8'h1C);

    send_byte(8'h14); send_byte(8'h11); send_byte(8'hE0); send_byte(8'h71);
    tick(8);
    n_cmp++;
    if (kbd_q.size() != 0) begin
      n_err++;
      $display("FAIL s6_kbd_pulse: pending=%0d expected 0", kbd_q.size());
    end
    probe(8'hFE, 5'b11101, "s6_symshift");
    send_bits(frame(8'h1C, 1'b0, 1'b0), 4, 0);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    clear_model();
    tick(2);
    probe(8'h00, 5'b11111, "s6_reset_clear");
    send_byte(8'h1C);              probe(8'hFD, 5'b11110, "s6_idle_after_reset");
    send_byte(8'hF0); send_byte(8'h1C);

    for (int it = 0; it < 180; it++) begin
      act = $urandom_range(0, 99);
      if (act < 85) send_byte(rand_code());
      else if (act < 90) send_bits(frame(rand_code(), 1'b1, 1'b0), 11, 0);
      else if (act < 93) send_bits(frame(rand_code(), 1'b0, 1'b1), 11, 0);
      else if (act < 97) begin
        send_bits(frame(rand_code(), 1'b0, 1'b0), $urandom_range(1, 10), 0);
        tick(TMO + 16);
      end else send_bits(11'h001, 1, 0);
      probe_model(rand_filas());
    end

    tick(10);
    n_cmp++;
    if (kbd_q.size() != 0) begin
      n_err++;
      $display("FAIL kbd_pending: pending=%0d expected 0", kbd_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
